// File: rtl/riscv_csr_regs.sv
// Machine-mode CSR state: combinational read decode and illegal-access detection,
// write commit, 64-bit cycle/instret counters, and trap-entry / MRET updates.
module riscv_csr_regs #(
  parameter int              XLEN          = 32,
  parameter int              HAS_RVC       = 0,
  parameter logic [XLEN-1:0] HARTID        = '0,
  parameter logic [XLEN-1:0] MTVEC_DEFAULT = 'h100
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_stall,
  input  logic [11:0]     ex_csr_reg,
  input  logic            ex_csr_we,
  input  logic [XLEN-1:0] ex_csr_wval,
  output logic [XLEN-1:0] st_csr_rval,
  output logic            st_csr_illegal,
  output logic [1:0]      st_xlen,
  input  logic            wb_retire,
  input  logic            wb_exception,
  input  logic [XLEN-1:0] wb_cause,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_badaddr,
  input  logic            wb_mret,
  output logic [XLEN-1:0] st_mtvec,
  output logic [XLEN-1:0] st_mepc,
  output logic            st_mie
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic            mie_bit, mpie_bit;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0]     mcycle_q, minstret_q;
  logic [XLEN-1:0] mstatus_v, misa_v;
  logic [63:0]     wval64;
  logic            mapped, wr;
  logic            w_mstatus, w_mie, w_mtvec, w_mscratch, w_mepc, w_mcause, w_mtval;
  logic            w_mcycle, w_mcycleh, w_minstret, w_minstreth;

  // mepc never holds a misaligned target: bit0 always clear, bit1 too without RVC.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r    = v;
    r[0] = 1'b0;
    if (HAS_RVC == 0) r[1] = 1'b0;
    return r;
  endfunction

  assign st_xlen  = (XLEN == 64) ? 2'b10 : 2'b01;
  assign wval64   = 64'(ex_csr_wval);
  assign st_mtvec = mtvec_q;
  assign st_mepc  = mepc_q;
  assign st_mie   = mie_bit;

  always_comb begin
    mstatus_v        = '0;
    mstatus_v[3]     = mie_bit;
    mstatus_v[7]     = mpie_bit;
    mstatus_v[12:11] = 2'b11;
    misa_v                  = '0;
    misa_v[XLEN-1:XLEN-2]   = st_xlen;
    misa_v[8]               = 1'b1;
    misa_v[2]               = (HAS_RVC != 0);
  end

  // Read decode; the *h counter words exist only on a 32-bit datapath.
  always_comb begin
    st_csr_rval = '0;
    mapped      = 1'b1;
    case (ex_csr_reg)
      A_MSTATUS:              st_csr_rval = mstatus_v;
      A_MISA:                 st_csr_rval = misa_v;
      A_MIE:                  st_csr_rval = mie_q;
      A_MTVEC:                st_csr_rval = mtvec_q;
      A_MSCRATCH:             st_csr_rval = mscratch_q;
      A_MEPC:                 st_csr_rval = mepc_q;
      A_MCAUSE:               st_csr_rval = mcause_q;
      A_MTVAL:                st_csr_rval = mtval_q;
      A_MCYCLE, A_CYCLE:      st_csr_rval = mcycle_q[XLEN-1:0];
      A_MINSTRET, A_INSTRET:  st_csr_rval = minstret_q[XLEN-1:0];
      A_MCYCLEH, A_CYCLEH: begin
        if (XLEN == 32) st_csr_rval = XLEN'(mcycle_q[63:32]);
        else            mapped      = 1'b0;
      end
      A_MINSTRETH, A_INSTRETH: begin
        if (XLEN == 32) st_csr_rval = XLEN'(minstret_q[63:32]);
        else            mapped      = 1'b0;
      end
      A_MVENDORID, A_MARCHID, A_MIMPID: st_csr_rval = '0;
      A_MHARTID:              st_csr_rval = HARTID;
      default:                mapped      = 1'b0;
    endcase
  end

  assign st_csr_illegal = !mapped || (ex_csr_we && (ex_csr_reg[11:10] == 2'b11));
  assign wr             = ex_csr_we && !ex_stall && !st_csr_illegal;

  assign w_mstatus   = wr && (ex_csr_reg == A_MSTATUS);
  assign w_mie       = wr && (ex_csr_reg == A_MIE);
  assign w_mtvec     = wr && (ex_csr_reg == A_MTVEC);
  assign w_mscratch  = wr && (ex_csr_reg == A_MSCRATCH);
  assign w_mepc      = wr && (ex_csr_reg == A_MEPC);
  assign w_mcause    = wr && (ex_csr_reg == A_MCAUSE);
  assign w_mtval     = wr && (ex_csr_reg == A_MTVAL);
  assign w_mcycle    = wr && (ex_csr_reg == A_MCYCLE);
  assign w_mcycleh   = wr && (ex_csr_reg == A_MCYCLEH);
  assign w_minstret  = wr && (ex_csr_reg == A_MINSTRET);
  assign w_minstreth = wr && (ex_csr_reg == A_MINSTRETH);

  // Trap entry outranks MRET, which outranks an EX write, field by field.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mie_bit    <= 1'b0;
      mpie_bit   <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_DEFAULT;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (wb_exception) begin
        mpie_bit <= mie_bit;
        mie_bit  <= 1'b0;
      end else if (wb_mret) begin
        mie_bit  <= mpie_bit;
        mpie_bit <= 1'b1;
      end else if (w_mstatus) begin
        mie_bit  <= ex_csr_wval[3];
        mpie_bit <= ex_csr_wval[7];
      end

      if (wb_exception) begin
        mepc_q   <= align_pc(wb_pc);
        mcause_q <= wb_cause;
        mtval_q  <= wb_badaddr;
      end else begin
        if (w_mepc)   mepc_q   <= align_pc(ex_csr_wval);
        if (w_mcause) mcause_q <= ex_csr_wval;
        if (w_mtval)  mtval_q  <= ex_csr_wval;
      end

      if (w_mie)      mie_q      <= ex_csr_wval;
      if (w_mscratch) mscratch_q <= ex_csr_wval;
      // mtvec mode 2/3 are reserved and collapse to direct mode.
      if (w_mtvec)
        mtvec_q <= {ex_csr_wval[XLEN-1:2], 1'b0, ex_csr_wval[1] ? 1'b0 : ex_csr_wval[0]};
    end
  end

  // A write to either counter word replaces that cycle's increment entirely.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (w_mcycle) begin
        if (XLEN == 32) mcycle_q <= {mcycle_q[63:32], wval64[31:0]};
        else            mcycle_q <= wval64;
      end else if (w_mcycleh) begin
        mcycle_q <= {wval64[31:0], mcycle_q[31:0]};
      end else begin
        mcycle_q <= mcycle_q + 64'd1;
      end

      if (w_minstret) begin
        if (XLEN == 32) minstret_q <= {minstret_q[63:32], wval64[31:0]};
        else            minstret_q <= wval64;
      end else if (w_minstreth) begin
        minstret_q <= {wval64[31:0], minstret_q[31:0]};
      end else if (wb_retire) begin
        minstret_q <= minstret_q + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_csr_regs.sv
// Directed bench for riscv_csr_regs: two instances (RVC on / off) share stimulus;
// expected values are queued by the driver and checked by a negedge monitor.
module tb_riscv_csr_regs;

  localparam int W = 35;  // {sel[1:0], illegal/mie, value[31:0]}

  logic        clk, rstn;
  logic        ex_stall, ex_csr_we;
  logic [11:0] ex_csr_reg;
  logic [31:0] ex_csr_wval;
  logic        wb_retire, wb_exception, wb_mret;
  logic [31:0] wb_cause, wb_pc, wb_badaddr;

  logic [31:0] rval_a, rval_b, mtvec_a, mtvec_b, mepc_a, mepc_b;
  logic        ill_a, ill_b, mie_a, mie_b;
  logic [1:0]  xlen_a, xlen_b;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         chk_req;
  int           total, bad;

  riscv_csr_regs #(.XLEN(32), .HAS_RVC(1), .HARTID(32'd5), .MTVEC_DEFAULT(32'h100)) u_a (
    .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .ex_csr_reg(ex_csr_reg),
    .ex_csr_we(ex_csr_we), .ex_csr_wval(ex_csr_wval), .st_csr_rval(rval_a),
    .st_csr_illegal(ill_a), .st_xlen(xlen_a), .wb_retire(wb_retire),
    .wb_exception(wb_exception), .wb_cause(wb_cause), .wb_pc(wb_pc),
    .wb_badaddr(wb_badaddr), .wb_mret(wb_mret), .st_mtvec(mtvec_a),
    .st_mepc(mepc_a), .st_mie(mie_a)
  );

  riscv_csr_regs #(.XLEN(32), .HAS_RVC(0), .HARTID(32'd0), .MTVEC_DEFAULT(32'h100)) u_b (
    .clk(clk), .rstn(rstn), .ex_stall(ex_stall), .ex_csr_reg(ex_csr_reg),
    .ex_csr_we(ex_csr_we), .ex_csr_wval(ex_csr_wval), .st_csr_rval(rval_b),
    .st_csr_illegal(ill_b), .st_xlen(xlen_b), .wb_retire(wb_retire),
    .wb_exception(wb_exception), .wb_cause(wb_cause), .wb_pc(wb_pc),
    .wb_badaddr(wb_badaddr), .wb_mret(wb_mret), .st_mtvec(mtvec_b),
    .st_mepc(mepc_b), .st_mie(mie_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Driver tasks: each step owns exactly one clock cycle of EX inputs.
  task automatic step(input logic [11:0] a, input logic we, input logic [31:0] wv,
                      input logic st);
    @(posedge clk);
    #1;
    ex_csr_reg   = a;
    ex_csr_we    = we;
    ex_csr_wval  = wv;
    ex_stall     = st;
    wb_retire    = 1'b0;
    wb_exception = 1'b0;
    wb_mret      = 1'b0;
    chk_req      = 1'b0;
  endtask

  // sel 0: {ill_a, rval_a}  1: {ill_b, rval_b}  2: {0, st_mtvec}  3: {st_mie, st_mepc}
  task automatic expect_v(input logic [1:0] sel, input logic [32:0] v, input string nm);
    exp_q.push_back({sel, v});
    name_q.push_back(nm);
    chk_req = 1'b1;
  endtask

  // Scoreboard monitor
  logic [W-1:0] mon_e;
  logic [32:0]  mon_obs;
  string        mon_nm;
  always @(negedge clk) begin
    if (chk_req) begin
      while (exp_q.size() > 0) begin
        mon_e  = exp_q.pop_front();
        mon_nm = name_q.pop_front();
        case (mon_e[34:33])
          2'd0:    mon_obs = {ill_a, rval_a};
          2'd1:    mon_obs = {ill_b, rval_b};
          2'd2:    mon_obs = {1'b0, mtvec_a};
          default: mon_obs = {mie_a, mepc_a};
        endcase
        total++;
        if (mon_obs !== mon_e[32:0]) begin
          bad++;
          $display("FAIL %s: got %h expected %h", mon_nm, mon_obs, mon_e[32:0]);
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0; chk_req = 1'b0; rstn = 1'b0;
    ex_stall = 1'b0; ex_csr_we = 1'b0; ex_csr_reg = '0; ex_csr_wval = '0;
    wb_retire = 1'b0; wb_exception = 1'b0; wb_mret = 1'b0;
    wb_cause = '0; wb_pc = '0; wb_badaddr = '0;

    // Reset state
    step(12'h305, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h100}, "reset_mtvec_read");
    expect_v(2, {1'b0, 32'h100}, "reset_st_mtvec");
    expect_v(3, {1'b0, 32'h0},   "reset_mie_mepc");
    step(12'h305, 1'b0, 32'h0, 1'b0);
    rstn = 1'b1;

    step(12'h301, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h40000104}, "misa_rvc1");
    expect_v(1, {1'b0, 32'h40000100}, "misa_rvc0");
    step(12'hF14, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h5}, "mhartid_a");
    expect_v(1, {1'b0, 32'h0}, "mhartid_b");

    // Stalled write is dropped
    step(12'h340, 1'b1, 32'hDEADBEEF, 1'b1);
    expect_v(0, {1'b0, 32'h0}, "mscratch_stall_cycle");
    step(12'h340, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h0}, "mscratch_after_stall");
    step(12'h340, 1'b1, 32'hDEADBEEF, 1'b0);
    step(12'h340, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'hDEADBEEF}, "mscratch_written");

    // WARL fields
    step(12'h305, 1'b1, 32'h203, 1'b0);
    step(12'h305, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h200}, "mtvec_mode3");
    expect_v(2, {1'b0, 32'h200}, "st_mtvec_mode3");
    step(12'h305, 1'b1, 32'h201, 1'b0);
    step(12'h305, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h201}, "mtvec_mode1");
    step(12'h341, 1'b1, 32'h1003, 1'b0);
    step(12'h341, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h1002}, "mepc_rvc1");
    expect_v(1, {1'b0, 32'h1000}, "mepc_rvc0");
    expect_v(3, {1'b0, 32'h1002}, "st_mepc_rvc1");

    // Counter low-to-high carry
    step(12'hB00, 1'b1, 32'hFFFFFFFF, 1'b0);
    step(12'hB80, 1'b1, 32'h0, 1'b0);
    step(12'hB00, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'hFFFFFFFF}, "mcycle_loaded");
    step(12'hB80, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h1}, "mcycleh_carry");
    step(12'hC00, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h1}, "cycle_shadow");
    step(12'hC00, 1'b1, 32'h12345678, 1'b0);
    expect_v(0, {1'b1, 32'h2}, "cycle_write_illegal");
    step(12'hB00, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h3}, "mcycle_unaffected");
    step(12'hC80, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h1}, "cycleh_shadow");
    step(12'h7C0, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b1, 32'h0}, "unmapped_read");

    // minstret: write beats the retire increment
    step(12'hB02, 1'b1, 32'h55, 1'b0);
    wb_retire = 1'b1;
    step(12'hB02, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h55}, "minstret_write_wins");
    step(12'hB02, 1'b0, 32'h0, 1'b0);
    wb_retire = 1'b1;
    expect_v(0, {1'b0, 32'h55}, "minstret_no_retire");
    step(12'hB02, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h56}, "minstret_retired");

    // Trap entry with a concurrent mscratch write, then MRET
    step(12'h300, 1'b1, 32'h8, 1'b0);
    step(12'h300, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h1808}, "mstatus_mie_set");
    expect_v(3, {1'b1, 32'h1002}, "st_mie_set");
    step(12'h340, 1'b1, 32'hCAFEF00D, 1'b0);
    wb_exception = 1'b1; wb_pc = 32'h80; wb_cause = 32'h2; wb_badaddr = 32'h44;
    step(12'h341, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h80}, "trap_mepc");
    expect_v(3, {1'b0, 32'h80}, "trap_st_mie_mepc");
    step(12'h342, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h2}, "trap_mcause");
    step(12'h343, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h44}, "trap_mtval");
    step(12'h300, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h1880}, "trap_mstatus");
    step(12'h340, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'hCAFEF00D}, "trap_mscratch_kept");
    wb_mret = 1'b1;
    step(12'h300, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h1888}, "mret_mstatus");
    expect_v(3, {1'b1, 32'h80}, "mret_st_mie");

    // Exception, MRET and mstatus write together: exception wins
    step(12'h300, 1'b1, 32'h0, 1'b0);
    wb_exception = 1'b1; wb_mret = 1'b1; wb_pc = 32'h103; wb_cause = 32'h7;
    step(12'h300, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h1880}, "prio_mstatus");
    step(12'h341, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h102}, "prio_mepc_rvc1");
    expect_v(1, {1'b0, 32'h100}, "prio_mepc_rvc0");
    step(12'h342, 1'b0, 32'h0, 1'b0);
    expect_v(0, {1'b0, 32'h7}, "prio_mcause");

    // Asynchronous reset mid-run
    step(12'h340, 1'b0, 32'h0, 1'b0);
    #1 rstn = 1'b0;
    expect_v(0, {1'b0, 32'h0},   "async_reset_mscratch");
    expect_v(2, {1'b0, 32'h100}, "async_reset_mtvec");
    expect_v(3, {1'b0, 32'h0},   "async_reset_mie_mepc");
    step(12'h340, 1'b0, 32'h0, 1'b0);
    rstn = 1'b1;
    step(12'h000, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
